// File: rtl/asp_irq_pkg.sv
// Shared constants for the ASP interrupt controller: CSR word map, handshake states,
// default line count and the board's fixed line assignments.
package asp_irq_pkg;

  localparam int DEFAULT_NUM_IRQ = 4;

  localparam int IRQ_DMA_0  = 0;
  localparam int IRQ_KERNEL = 1;
  localparam int IRQ_DMA_1  = 2;

  localparam logic [31:0] CSR_STATUS     = 32'd0;
  localparam logic [31:0] CSR_ENABLE     = 32'd1;
  localparam logic [31:0] CSR_CLEAR      = 32'd2;
  localparam logic [31:0] CSR_MODE       = 32'd3;
  localparam logic [31:0] CSR_RAW        = 32'd4;
  localparam logic [31:0] CSR_PARAMS     = 32'd5;
  localparam logic [31:0] CSR_REQ_CNT    = 32'd6;
  localparam logic [31:0] CSR_STATS_CLR  = 32'd7;
  localparam logic [31:0] CSR_STATS_BASE = 32'd8;

  localparam logic [31:0] STATS_CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ARMED
  } irq_state_t;

  function automatic logic [63:0] byte_mask(input logic [7:0] be);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{be[b]}};
    return m;
  endfunction

endpackage

// File: rtl/asp_irq_line.sv
// One interrupt line: input register, edge/level capture into the pending bit (set beats clear).
// With ASP_IRQ_STATS_EN defined, also a saturating count of pending 0->1 transitions.
module asp_irq_line
  import asp_irq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        irq_in,
  input  logic        mode,
  input  logic        clr,
`ifdef ASP_IRQ_STATS_EN
  input  logic        cnt_clr,
  input  logic        cnt_load,
  input  logic [31:0] cnt_load_val,
  output logic [31:0] count,
`endif
  output logic        pending
);

  logic irq_in_q;
  logic primed;
  logic rise;
  logic pending_next;

  // primed masks the first cycle after reset so a source held high through reset
  // is not mistaken for a fresh rising edge.
  assign rise = irq_in & ~irq_in_q & primed;

  always_comb begin
    if (mode) pending_next = rise | (pending & ~clr);
    else      pending_next = irq_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_in_q <= 1'b0;
      primed   <= 1'b0;
      pending  <= 1'b0;
    end else begin
      irq_in_q <= irq_in;
      primed   <= 1'b1;
      pending  <= pending_next;
    end
  end

`ifdef ASP_IRQ_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (cnt_clr) begin
      count <= '0;
    end else if (cnt_load) begin
      count <= cnt_load_val;
    end else if (pending_next && !pending && count != STATS_CNT_MAX) begin
      count <= count + 32'd1;
    end
  end
`endif

endmodule

// File: rtl/asp_irq_ctrl.sv
// NUM_IRQ-line interrupt aggregator with a request/ack host handshake and a 64-bit CSR slave.
// Define ASP_IRQ_STATS_EN to build the per-line and request event counters.
module asp_irq_ctrl
  import asp_irq_pkg::*;
#(
  parameter int                 NUM_IRQ        = DEFAULT_NUM_IRQ,
  parameter int                 CSR_ADDR_WIDTH = 4,
  parameter logic [NUM_IRQ-1:0] EDGE_MODE_RST  = '1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_IRQ-1:0]        irq_in,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_address,
  input  logic                      csr_read,
  input  logic                      csr_write,
  input  logic [63:0]               csr_writedata,
  input  logic [7:0]                csr_byteenable,
  output logic [63:0]               csr_readdata,
  output logic                      csr_readdatavalid,
  output logic                      csr_waitrequest,
  output logic                      irq_req,
  input  logic                      irq_ack
);

  logic [31:0]        addr;
  logic [63:0]        wmask;
  logic [NUM_IRQ-1:0] lmask;
  logic [NUM_IRQ-1:0] wdata_l;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] enable;
  logic [NUM_IRQ-1:0] mode;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] vec;
  logic [NUM_IRQ-1:0] vec_q;
  logic [NUM_IRQ-1:0] rise;
  logic               active;
  logic               req_set;
  logic [63:0]        rd_data;
  irq_state_t         state;
  logic               unused_wdata;

  assign addr    = 32'(csr_address);
  assign wmask   = byte_mask(csr_byteenable);
  assign lmask   = wmask[NUM_IRQ-1:0];
  assign wdata_l = csr_writedata[NUM_IRQ-1:0];
  assign unused_wdata = ^{csr_writedata, wmask};
  assign csr_waitrequest = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable <= '0;
      mode   <= EDGE_MODE_RST;
    end else if (csr_write) begin
      if (addr == CSR_ENABLE) enable <= (enable & ~lmask) | (wdata_l & lmask);
      if (addr == CSR_MODE)   mode   <= (mode & ~lmask) | (wdata_l & lmask);
    end
  end

  assign clr = (csr_write && addr == CSR_CLEAR) ? (wdata_l & lmask) : '0;

`ifdef ASP_IRQ_STATS_EN
  // CSR_ADDR_WIDTH must cover 8+NUM_IRQ words or counter addresses alias.
  logic        cnt_clr;
  logic [31:0] count [NUM_IRQ];
  logic [7:0]  req_cnt;
  assign cnt_clr = csr_write && addr == CSR_STATS_CLR;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_line
`ifdef ASP_IRQ_STATS_EN
      logic        cnt_load;
      logic [31:0] cnt_load_val;
      assign cnt_load     = csr_write && addr == CSR_STATS_BASE + 32'(gi);
      assign cnt_load_val = (count[gi] & ~wmask[31:0]) | (csr_writedata[31:0] & wmask[31:0]);
`endif
      asp_irq_line u_line (
        .clk          (clk),
        .reset        (reset),
        .irq_in       (irq_in[gi]),
        .mode         (mode[gi]),
        .clr          (clr[gi]),
`ifdef ASP_IRQ_STATS_EN
        .cnt_clr      (cnt_clr),
        .cnt_load     (cnt_load),
        .cnt_load_val (cnt_load_val),
        .count        (count[gi]),
`endif
        .pending      (pending[gi])
      );
    end
  endgenerate

  assign vec     = pending & enable;
  assign active  = |vec;
  assign rise    = vec & ~vec_q;
  assign req_set = (state == IDLE && active) || (state == ARMED && (|rise));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      irq_req <= 1'b0;
      vec_q   <= '0;
    end else begin
      vec_q <= vec;
      case (state)
        IDLE: begin
          if (active) begin
            state   <= REQ;
            irq_req <= 1'b1;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state   <= ARMED;
            irq_req <= 1'b0;
          end
        end
        ARMED: begin
          // Only a newly asserted source re-requests; lingering ones wait for software.
          if (|rise) begin
            state   <= REQ;
            irq_req <= 1'b1;
          end else if (!active) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef ASP_IRQ_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_cnt <= '0;
    end else if (cnt_clr) begin
      req_cnt <= '0;
    end else if (req_set && req_cnt != 8'hFF) begin
      req_cnt <= req_cnt + 8'd1;
    end
  end
`endif

  always_comb begin
    rd_data = '0;
    case (addr)
      CSR_STATUS: rd_data = 64'(pending);
      CSR_ENABLE: rd_data = 64'(enable);
      CSR_MODE:   rd_data = 64'(mode);
      CSR_RAW:    rd_data = 64'(irq_in);
      CSR_PARAMS: rd_data = {56'd0, 8'(NUM_IRQ)};
`ifdef ASP_IRQ_STATS_EN
      CSR_REQ_CNT: rd_data = {56'd0, req_cnt};
`endif
      default: rd_data = '0;
    endcase
`ifdef ASP_IRQ_STATS_EN
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (addr == CSR_STATS_BASE + 32'(i)) rd_data = {32'd0, count[i]};
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csr_readdata      <= '0;
      csr_readdatavalid <= 1'b0;
    end else begin
      csr_readdatavalid <= csr_read;
      csr_readdata      <= csr_read ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_asp_irq_ctrl.sv
// Self-checking bench for asp_irq_ctrl: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the controller's rules.
module tb_asp_irq_ctrl;

  localparam int N  = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  irq_in = '0;
  logic [AW-1:0] csr_address = '0;
  logic          csr_read = 1'b0;
  logic          csr_write = 1'b0;
  logic [63:0]   csr_writedata = '0;
  logic [7:0]    csr_byteenable = '0;
  logic [63:0]   csr_readdata;
  logic          csr_readdatavalid;
  logic          csr_waitrequest;
  logic          irq_req;
  logic          irq_ack = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  asp_irq_ctrl #(
    .NUM_IRQ        (N),
    .CSR_ADDR_WIDTH (AW),
    .EDGE_MODE_RST  (4'hF)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .irq_in            (irq_in),
    .csr_address       (csr_address),
    .csr_read          (csr_read),
    .csr_write         (csr_write),
    .csr_writedata     (csr_writedata),
    .csr_byteenable    (csr_byteenable),
    .csr_readdata      (csr_readdata),
    .csr_readdatavalid (csr_readdatavalid),
    .csr_waitrequest   (csr_waitrequest),
    .irq_req           (irq_req),
    .irq_ack           (irq_ack)
  );

  // Behavioural model state
  logic [N-1:0] m_pend, m_en, m_mode, m_prev, m_vprev;
  logic         m_primed, m_req, m_armed, m_rd_valid;
  logic [63:0]  m_rd_data;
`ifdef ASP_IRQ_STATS_EN
  logic [31:0]  m_cnt [N];
  logic [7:0]   m_req_cnt;
`endif

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_mode = '1; m_prev = '0; m_vprev = '0;
    m_primed = 1'b0; m_req = 1'b0; m_armed = 1'b0;
    m_rd_valid = 1'b0; m_rd_data = '0;
`ifdef ASP_IRQ_STATS_EN
    for (int i = 0; i < N; i++) m_cnt[i] = '0;
    m_req_cnt = '0;
`endif
  endtask

  function automatic logic [63:0] model_read(input int a);
    logic [63:0] r;
    r = '0;
    case (a)
      0: r = 64'(m_pend);
      1: r = 64'(m_en);
      3: r = 64'(m_mode);
      4: r = 64'(irq_in);
      5: r = 64'(N);
`ifdef ASP_IRQ_STATS_EN
      6: r = 64'(m_req_cnt);
`endif
      default: r = '0;
    endcase
`ifdef ASP_IRQ_STATS_EN
    if (a >= 8 && a < 8 + N) r = 64'(m_cnt[a-8]);
`endif
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs the bench is driving.
  task automatic model_update();
    logic [63:0]  bm, rd;
    logic [N-1:0] np, vec, wd, clr;
    logic         old_req;
    int           a;
    if (reset) begin
      model_reset();
      return;
    end
    a = int'(csr_address);
    for (int b = 0; b < 8; b++) bm[b*8 +: 8] = {8{csr_byteenable[b]}};
    wd  = csr_writedata[N-1:0] & bm[N-1:0];
    clr = (csr_write && a == 2) ? wd : '0;
    rd  = model_read(a);
    for (int i = 0; i < N; i++) begin
      if (m_mode[i]) np[i] = (irq_in[i] && !m_prev[i] && m_primed) ? 1'b1 : (m_pend[i] && !clr[i]);
      else           np[i] = irq_in[i];
    end
    vec = m_pend & m_en;
    old_req = m_req;
    if (m_req) begin
      if (irq_ack) begin m_req = 1'b0; m_armed = 1'b1; end
    end else if (m_armed) begin
      if ((vec & ~m_vprev) != '0) begin m_req = 1'b1; m_armed = 1'b0; end
      else if (vec == '0) m_armed = 1'b0;
    end else if (vec != '0) begin
      m_req = 1'b1;
    end
`ifdef ASP_IRQ_STATS_EN
    if (csr_write && a == 7) m_req_cnt = '0;
    else if (m_req && !old_req && m_req_cnt != 8'hFF) m_req_cnt = m_req_cnt + 8'd1;
    for (int i = 0; i < N; i++) begin
      if (csr_write && a == 7) m_cnt[i] = '0;
      else if (csr_write && a == 8 + i) m_cnt[i] = (m_cnt[i] & ~bm[31:0]) | (csr_writedata[31:0] & bm[31:0]);
      else if (np[i] && !m_pend[i] && m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 32'd1;
    end
`endif
    m_rd_valid = csr_read;
    m_rd_data  = csr_read ? rd : '0;
    if (csr_write && a == 1) m_en   = (m_en & ~bm[N-1:0]) | wd;
    if (csr_write && a == 3) m_mode = (m_mode & ~bm[N-1:0]) | wd;
    m_vprev  = vec;
    m_prev   = irq_in;
    m_primed = 1'b1;
    m_pend   = np;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic csr_wr(input int a, input logic [63:0] d, input logic [7:0] be);
    csr_address = AW'(a); csr_writedata = d; csr_byteenable = be; csr_write = 1'b1;
    step();
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input int a, output logic [63:0] d, output logic v);
    csr_address = AW'(a); csr_read = 1'b1;
    step();
    csr_read = 1'b0;
    d = csr_readdata; v = csr_readdatavalid;
  endtask

  task automatic do_reset();
    irq_in = '0; irq_ack = 1'b0; csr_read = 1'b0; csr_write = 1'b0;
    reset = 1'b1; model_reset();
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    int          addrs [6];
    logic [63:0] exps  [6];
    logic [63:0] d;
    logic        v;
    addrs = '{0, 1, 3, 5, 6, 15};
    exps  = '{64'h0, 64'h0, 64'hF, 64'h4, 64'h0, 64'h0};
    do_reset();
    n_checks++; if (irq_req !== 1'b0) $display("FAIL rst_irq_req: got %b expected 0", irq_req); else n_pass++;
    n_checks++; if (csr_readdatavalid !== 1'b0) $display("FAIL rst_rdvalid: got %b expected 0", csr_readdatavalid); else n_pass++;
    n_checks++; if (csr_readdata !== 64'h0) $display("FAIL rst_rdata: got %0h expected 0", csr_readdata); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      csr_rd(addrs[k], d, v);
      n_checks++; if (v !== 1'b1) $display("FAIL rst_rd_valid a%0d: got %b expected 1", addrs[k], v); else n_pass++;
      n_checks++; if (d !== exps[k]) $display("FAIL rst_rd a%0d: got %0h expected %0h", addrs[k], d, exps[k]); else n_pass++;
    end
    step();
    n_checks++; if (csr_readdatavalid !== 1'b0) $display("FAIL rdvalid_one_cycle: got %b expected 0", csr_readdatavalid); else n_pass++;
  endtask

  task automatic test_edge_basic();
    logic [63:0] d;
    logic        v;
    do_reset();
    csr_wr(1, 64'h2, 8'hFF);
    irq_in = 4'b0010; step(); irq_in = '0;
    n_checks++; if (irq_req !== 1'b0) $display("FAIL edge_req_early: got %b expected 0", irq_req); else n_pass++;
    step();
    n_checks++; if (irq_req !== 1'b1) $display("FAIL edge_req_rise: got %b expected 1", irq_req); else n_pass++;
    csr_rd(0, d, v);
    n_checks++; if (d !== 64'h2) $display("FAIL edge_status: got %0h expected 2", d); else n_pass++;
    n_checks++; if (irq_req !== 1'b1) $display("FAIL edge_req_held: got %b expected 1", irq_req); else n_pass++;
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    n_checks++; if (irq_req !== 1'b0) $display("FAIL edge_req_ack: got %b expected 0", irq_req); else n_pass++;
    csr_wr(2, 64'h2, 8'hFF);
    step();
    csr_rd(0, d, v);
    n_checks++; if (d !== 64'h0) $display("FAIL edge_cleared: got %0h expected 0", d); else n_pass++;
    csr_rd(2, d, v);
    n_checks++; if (d !== 64'h0) $display("FAIL clear_reads_zero: got %0h expected 0", d); else n_pass++;
    irq_in = 4'b0010; step(); irq_in = '0; step();
    n_checks++; if (irq_req !== 1'b1) $display("FAIL edge_req_again: got %b expected 1", irq_req); else n_pass++;
  endtask

  task automatic test_rearm();
    logic [63:0] d;
    logic        v;
    do_reset();
    csr_wr(1, 64'h3, 8'hFF);
    irq_in = 4'b0001; step(); irq_in = '0; step();
    n_checks++; if (irq_req !== 1'b1) $display("FAIL rearm_req0: got %b expected 1", irq_req); else n_pass++;
    irq_ack = 1'b1; step(); irq_ack = 1'b0; step();
    n_checks++; if (irq_req !== 1'b0) $display("FAIL rearm_armed: got %b expected 0", irq_req); else n_pass++;
    irq_in = 4'b0010; step(); irq_in = '0; step();
    n_checks++; if (irq_req !== 1'b1) $display("FAIL rearm_req1: got %b expected 1", irq_req); else n_pass++;
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    csr_wr(2, 64'h1, 8'hFF);
    step(); step(); step();
    n_checks++; if (irq_req !== 1'b0) $display("FAIL rearm_no_new_req: got %b expected 0", irq_req); else n_pass++;
    csr_rd(0, d, v);
    n_checks++; if (d !== 64'h2) $display("FAIL rearm_status: got %0h expected 2", d); else n_pass++;
  endtask

  task automatic test_level_mode();
    logic [63:0] d;
    logic        v;
    do_reset();
    csr_wr(3, 64'h0, 8'hFF);
    csr_wr(1, 64'h4, 8'hFF);
    irq_in = 4'b0100; step(); step();
    csr_rd(0, d, v);
    n_checks++; if (d !== 64'h4) $display("FAIL level_status: got %0h expected 4", d); else n_pass++;
    csr_rd(4, d, v);
    n_checks++; if (d !== 64'h4) $display("FAIL raw_read: got %0h expected 4", d); else n_pass++;
    csr_wr(2, 64'h4, 8'hFF);
    csr_rd(0, d, v);
    n_checks++; if (d !== 64'h4) $display("FAIL level_clear_ignored: got %0h expected 4", d); else n_pass++;
    csr_wr(3, 64'hF, 8'hFF);
    step();
    csr_rd(0, d, v);
    n_checks++; if (d !== 64'h4) $display("FAIL level_to_edge_keep: got %0h expected 4", d); else n_pass++;
    csr_wr(2, 64'h4, 8'hFF);
    csr_rd(0, d, v);
    n_checks++; if (d !== 64'h0) $display("FAIL edge_held_no_recapture: got %0h expected 0", d); else n_pass++;
    csr_wr(3, 64'h0, 8'hFF);
    step();
    irq_in = '0; step();
    csr_rd(0, d, v);
    n_checks++; if (d !== 64'h0) $display("FAIL level_drop: got %0h expected 0", d); else n_pass++;
  endtask

  task automatic test_set_wins_clear();
    logic [63:0] d;
    logic        v;
    do_reset();
    csr_address = AW'(2); csr_writedata = 64'h1; csr_byteenable = 8'hFF; csr_write = 1'b1;
    irq_in = 4'b0001;
    step();
    csr_write = 1'b0; irq_in = '0;
    csr_rd(0, d, v);
    n_checks++; if (d !== 64'h1) $display("FAIL set_wins_clear: got %0h expected 1", d); else n_pass++;
    csr_wr(2, 64'h1, 8'h00);
    csr_rd(0, d, v);
    n_checks++; if (d !== 64'h1) $display("FAIL clear_be_off: got %0h expected 1", d); else n_pass++;
    csr_wr(2, 64'h1, 8'h01);
    csr_rd(0, d, v);
    n_checks++; if (d !== 64'h0) $display("FAIL clear_works: got %0h expected 0", d); else n_pass++;
    csr_wr(1, 64'hF, 8'hFE);
    csr_rd(1, d, v);
    n_checks++; if (d !== 64'h0) $display("FAIL enable_be_masked: got %0h expected 0", d); else n_pass++;
    csr_wr(1, 64'hFF, 8'h01);
    csr_rd(1, d, v);
    n_checks++; if (d !== 64'hF) $display("FAIL enable_be_write: got %0h expected f", d); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    logic        v;
    do_reset();
    csr_wr(1, 64'h1, 8'hFF);
    irq_in = 4'b0001;
    for (int k = 0; k < 8 && irq_req !== 1'b1; k++) step();
    n_checks++; if (irq_req !== 1'b1) $display("FAIL mid_req_wait: got %b expected 1", irq_req); else n_pass++;
    #2 reset = 1'b1; model_reset();
    #1;
    n_checks++; if (irq_req !== 1'b0) $display("FAIL mid_async_req: got %b expected 0", irq_req); else n_pass++;
    step(); step();
    reset = 1'b0;
    step(); step(); step();
    csr_rd(0, d, v);
    n_checks++; if (d !== 64'h0) $display("FAIL mid_edge_no_recapture: got %0h expected 0", d); else n_pass++;
    n_checks++; if (irq_req !== 1'b0) $display("FAIL mid_req_after: got %b expected 0", irq_req); else n_pass++;
    csr_rd(1, d, v);
    n_checks++; if (d !== 64'h0) $display("FAIL mid_enable_rst: got %0h expected 0", d); else n_pass++;
    csr_rd(3, d, v);
    n_checks++; if (d !== 64'hF) $display("FAIL mid_mode_rst: got %0h expected f", d); else n_pass++;
    csr_wr(3, 64'hE, 8'hFF);
    step();
    csr_rd(0, d, v);
    n_checks++; if (d !== 64'h1) $display("FAIL mid_level_recapture: got %0h expected 1", d); else n_pass++;
    irq_in = '0;
  endtask

`ifdef ASP_IRQ_STATS_EN
  task automatic test_stats();
    logic [63:0] d;
    logic        v;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      irq_in = 4'b1000; step(); irq_in = '0;
      csr_wr(2, 64'h8, 8'hFF);
    end
    csr_rd(11, d, v);
    n_checks++; if (d !== 64'h3) $display("FAIL stats_count3: got %0h expected 3", d); else n_pass++;
    csr_rd(6, d, v);
    n_checks++; if (d !== 64'h0) $display("FAIL stats_req_cnt: got %0h expected 0", d); else n_pass++;
    csr_wr(7, 64'h0, 8'hFF);
    csr_rd(11, d, v);
    n_checks++; if (d !== 64'h0) $display("FAIL stats_cleared: got %0h expected 0", d); else n_pass++;
    csr_wr(11, 64'hFFFF_FFFE, 8'hFF);
    for (int k = 0; k < 2; k++) begin
      irq_in = 4'b1000; step(); irq_in = '0;
      csr_wr(2, 64'h8, 8'hFF);
    end
    csr_rd(11, d, v);
    n_checks++; if (d !== 64'hFFFF_FFFF) $display("FAIL stats_saturate: got %0h expected ffffffff", d); else n_pass++;
  endtask
`endif

  task automatic test_random();
    int wr_addrs [5];
    int op;
    wr_addrs = '{1, 2, 3, 7, 11};
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 3) == 0) irq_in = N'($urandom);
      irq_ack = ($urandom_range(0, 2) == 0);
      op = $urandom_range(0, 3);
      csr_read = 1'b0; csr_write = 1'b0;
      if (op == 1) begin
        csr_read = 1'b1; csr_address = AW'($urandom_range(0, 15));
      end else if (op == 2) begin
        csr_write = 1'b1;
        csr_address = AW'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : wr_addrs[$urandom_range(0, 4)]);
        csr_writedata = {$urandom, $urandom};
        csr_byteenable = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      end
      step();
      n_checks++; if (irq_req !== m_req) $display("FAIL rnd_irq_req cyc %0d: got %b expected %b", cyc, irq_req, m_req); else n_pass++;
      n_checks++; if (csr_readdatavalid !== m_rd_valid) $display("FAIL rnd_rdvalid cyc %0d: got %b expected %b", cyc, csr_readdatavalid, m_rd_valid); else n_pass++;
      if (m_rd_valid) begin
        n_checks++; if (csr_readdata !== m_rd_data) $display("FAIL rnd_rdata cyc %0d: got %0h expected %0h", cyc, csr_readdata, m_rd_data); else n_pass++;
      end
    end
    csr_read = 1'b0; csr_write = 1'b0; irq_ack = 1'b0; irq_in = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_edge_basic();
    test_rearm();
    test_level_mode();
    test_set_wins_clear();
    test_reset_mid();
`ifdef ASP_IRQ_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
